seq_detect_ctrl: RTL

Programmable serial-pattern detection controller. Accepts a pattern configuration through a valid/ready handshake, then sequences detection over a qualified serial bit stream. Counts matches, supports overlapping or non-overlapping detection, and stops at a programmable target count. It replaces hard-coded detector FSMs in the serial-input path with one configurable, run-controlled block.

---
 rtl/seq_detect_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - programmable serial-pattern detector with run control
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               stop,
  input  logic               bit_valid,
  input  logic               bit_in,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic [CNT_W-1:0]   tgt_q;
  logic               loaded_q;
  logic [MAX_LEN-1:0] hist_q;
  logic [LEN_W-1:0]   hcnt_q;
  logic               cfg_ready_q;
  logic               match_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;

  logic               cfg_hs;
  logic               len_ok;
  logic               cfg_acc;
  logic [MAX_LEN-1:0] hist_d;
  logic [LEN_W-1:0]   hcnt_d;
  logic [MAX_LEN-1:0] mask;
  logic               hit;
  logic [CNT_W-1:0]   cnt_d;

  assign cfg_ready   = cfg_ready_q;
  assign match       = match_q;
  assign match_count = cnt_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

  assign cfg_hs  = cfg_valid && cfg_ready_q;
  assign len_ok  = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  assign cfg_acc = cfg_hs && len_ok;

  assign hist_d = {hist_q[MAX_LEN-2:0], bit_in};
  assign hcnt_d = (hcnt_q == LEN_W'(MAX_LEN)) ? hcnt_q : hcnt_q + 1'b1;
  assign cnt_d  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  // Only the low len bits of history take part in the compare
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len_q));
    end
  end

  assign hit = (hcnt_d >= len_q) && (((hist_d ^ pat_q) & mask) == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      ovl_q       <= 1'b0;
      tgt_q       <= '0;
      loaded_q    <= 1'b0;
      hist_q      <= '0;
      hcnt_q      <= '0;
      cfg_ready_q <= 1'b1;
      match_q     <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      match_q <= 1'b0;
      err_q   <= 1'b0;

      if (cfg_hs) begin
        if (len_ok) begin
          pat_q    <= cfg_pattern;
          len_q    <= cfg_len;
          ovl_q    <= cfg_overlap;
          tgt_q    <= cfg_target;
          loaded_q <= 1'b1;
        end else begin
          err_q <= 1'b1;
        end
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          // A config landing in the same cycle takes priority over start
          if (start && !cfg_acc) begin
            if (loaded_q) begin
              state_q     <= S_RUN;
              cnt_q       <= '0;
              hist_q      <= '0;
              hcnt_q      <= '0;
              busy_q      <= 1'b1;
              done_q      <= 1'b0;
              cfg_ready_q <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (stop) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
          end else if (bit_valid) begin
            hist_q <= hist_d;
            hcnt_q <= (hit && !ovl_q) ? '0 : hcnt_d;
            if (hit) begin
              match_q <= 1'b1;
              cnt_q   <= cnt_d;
              if ((tgt_q != '0) && (cnt_d == tgt_q)) begin
                state_q     <= S_DONE;
                done_q      <= 1'b1;
                busy_q      <= 1'b0;
                cfg_ready_q <= 1'b1;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
